stereo_write_buffer: RTL and testbench
======================================

# stereo_write_buffer

Output stage between the two per-channel FIR filters and the audio CODEC write port. Each FIR signals its own completed 16-bit sample. This block pairs one left and one right sample into a stereo frame and queues frames in a small FIFO. It drives the CODEC `write` strobe and 24-bit left-justified data whenever the CODEC reports `write_ready`, which decouples filter completion timing from DAC timing.

## Interface
Parameters:
- `DATA_W`, 16, FIR sample width
- `DEPTH`, 8, FIFO frame capacity; power of two, minimum 2

Ports:
- `ck` in 1: single clock, CLOCK_50 domain
- `rst` in 1: synchronous, active-low reset
- `in_left` in DATA_W: left FIR output sample
- `in_left_valid` in 1: one-cycle pulse, left sample valid
- `in_right` in DATA_W: right FIR output sample
- `in_right_valid` in 1: one-cycle pulse, right sample valid
- `write_ready` in 1: CODEC can accept a frame this cycle
- `write` out 1: frame transfer this cycle
- `writedata_left` out 24: `{head.left, 8'h00}`
- `writedata_right` out 24: `{head.right, 8'h00}`
- `level` out $clog2(DEPTH)+1: frames currently queued
- `overflow` out 1: sticky; a completed frame was dropped because the FIFO was full
- `pair_err` out 1: sticky; a channel sample arrived while the same channel's previous sample was still unpaired

## Operation
- Each channel has a hold register plus a `held` flag. A valid pulse captures the sample and sets `held`.
- A frame completes in the cycle in which both channels are available, either held or arriving as a pulse in that cycle. At that rising edge:
  - the frame is pushed into the FIFO;
  - both `held` flags clear.
- If a channel pulses while its `held` flag is set and the frame does not complete:
  - the new sample overwrites the held one;
  - `pair_err` is set.
- Push when the FIFO is full and no pop occurs in the same cycle: the frame is discarded, `overflow` is set, and the `held` flags still clear.
- Push and pop in the same cycle while full: both succeed and `level` is unchanged.
- `write = (level != 0) && write_ready`. This is combinational from registered state and `write_ready`.
- A pop occurs on every cycle where `write` is high.
- `writedata_*` always present the FIFO head. With the FIFO empty they hold the last popped value, or 0 after reset.
- Pointers wrap modulo DEPTH. `level` is maintained as an explicit counter.

## Timing
- Reset (`rst` low at a rising edge) produces:
  - FIFO emptied and `level` = 0;
  - `held` flags = 0;
  - `overflow` = 0 and `pair_err` = 0;
  - `writedata_*` = 0, and `write` = 0.
- Reset in the middle of a partial pair or a full FIFO discards all contents. There is no partial frame after reset.
- Latency: a frame completed at edge N is visible at the head from cycle N+1. The earliest `write` is cycle N+1.
- There is no bypass: a push into an empty FIFO never produces `write` in the same cycle.
- Throughput: one push and one pop per cycle.

## Configuration
- `WRBUF_STATS_EN` defined:
  - adds output `drop_count` (16 bits), which increments once per discarded frame;
  - the counter saturates at 16'hFFFF;
  - the counter is cleared by reset.
- `WRBUF_STATS_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `wrbuf_pkg` contains:
  - `CODEC_W = 24`;
  - `DATA_W_DEFAULT = 16`;
  - `typedef struct packed { logic [DATA_W-1:0] left, right; } frame_t`.
- Sub-module `sync_fifo` (parameters WIDTH and DEPTH; signals push, pop, full, empty, level).
- The top block contains the pairing logic, the sticky flags and the output formatting.

## Test plan
- Pairing order: left pulse 16'h1234 at cycle 2, right pulse 16'hABCD at cycle 5, `write_ready` held high -> `write` high for exactly cycle 6 with `writedata_left` = 24'h123400 and `writedata_right` = 24'hABCD00.
- Simultaneous pairing and lost-left: left and right pulse together at cycle 3 (0x0001/0x0002) -> `write` at cycle 4. Then left pulses 0x0010 and 0x0020 with no right between them, followed by right 0x0030 -> `pair_err` = 1 and the frame is {0x0020, 0x0030}.
- Fill and overflow: `write_ready` = 0 while 9 frames are pushed -> `level` = 8 and `overflow` = 1. Then `write_ready` = 1 -> 8 frames are written in push order and the 9th is absent (`drop_count` = 1 when stats are enabled).
- Full boundary: with `level` = 8, a push and a pop in the same cycle -> `level` stays 8, `overflow` stays 0, and the new frame appears last.
- Reset: with 3 frames queued and a left sample held, drive `rst` low for one cycle -> all outputs are 0 the next cycle. A single right pulse then produces no write.
- Backpressure: `write_ready` toggles every cycle while 4 frames are queued -> `write` only occurs when `write_ready` = 1 and the data order is preserved.

Source files
------------

// File: rtl/wrbuf_pkg.sv
// Shared types and constants for the stereo write buffer.
package wrbuf_pkg;

  localparam int CODEC_W        = 24;
  localparam int DATA_W_DEFAULT = 16;
  localparam int DROP_W         = 16;

  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] left;
    logic [DATA_W_DEFAULT-1:0] right;
  } frame_t;

  // Saturating increment for the discarded-frame counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    logic [DROP_W-1:0] r;
    if (v == {DROP_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(DROP_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit level counter; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == {(AW+1){1'b0}});
  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

  // Accepted push/pop and next pointer/level values.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + {{AW{1'b0}}, 1'b1};
      2'b01:   level_d = level_q - {{AW{1'b0}}, 1'b1};
      default: level_d = level_q;
    endcase
  end

  // Pointer and level state.
  always_ff @(posedge ck) begin
    if (!rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the level counter.
  always_ff @(posedge ck) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/stereo_write_buffer.sv
// Pairs left/right FIR samples into stereo frames and feeds the CODEC.
// Optional WRBUF_STATS_EN adds a saturating discarded-frame counter.
module stereo_write_buffer
  import wrbuf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 8
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      in_left,
  input  logic                   in_left_valid,
  input  logic [DATA_W-1:0]      in_right,
  input  logic                   in_right_valid,
  input  logic                   write_ready,
  output logic                   write,
  output logic [CODEC_W-1:0]     writedata_left,
  output logic [CODEC_W-1:0]     writedata_right,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
`ifdef WRBUF_STATS_EN
  output logic                   pair_err,
  output logic [DROP_W-1:0]      drop_count
`else
  output logic                   pair_err
`endif
);

  localparam int FW = 2 * DATA_W;

  logic              held_l_q, held_l_d, held_r_q, held_r_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic              overflow_q, overflow_d;
  logic              pair_err_q, pair_err_d;
  logic [FW-1:0]     last_q, last_d;

  logic              complete, pop, dropped;
  logic [FW-1:0]     frame_din, fifo_dout, head;
  logic              fifo_full, fifo_empty;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ck    (ck),
    .rst   (rst),
    .push  (complete),
    .pop   (pop),
    .din   (frame_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign write           = pop;
  assign overflow        = overflow_q;
  assign pair_err        = pair_err_q;
  assign writedata_left  = {head[FW-1:DATA_W], {(CODEC_W-DATA_W){1'b0}}};
  assign writedata_right = {head[DATA_W-1:0],  {(CODEC_W-DATA_W){1'b0}}};

  // Pairing, sticky flags and head selection.
  always_comb begin
    pop       = ~fifo_empty & write_ready;
    complete  = (held_l_q | in_left_valid) & (held_r_q | in_right_valid);
    dropped   = complete & fifo_full & ~pop;
    frame_din = {(in_left_valid  ? in_left  : hold_l_q),
                 (in_right_valid ? in_right : hold_r_q)};
    hold_l_d  = in_left_valid  ? in_left  : hold_l_q;
    hold_r_d  = in_right_valid ? in_right : hold_r_q;
    if (complete) begin
      held_l_d = 1'b0;
      held_r_d = 1'b0;
    end else begin
      held_l_d = held_l_q | in_left_valid;
      held_r_d = held_r_q | in_right_valid;
    end
    // A re-arriving sample only counts as lost when the pair did not close.
    pair_err_d = pair_err_q |
                 (~complete & ((in_left_valid & held_l_q) | (in_right_valid & held_r_q)));
    overflow_d = overflow_q | dropped;
    if (pop) begin
      last_d = fifo_dout;
    end else begin
      last_d = last_q;
    end
    // An empty FIFO shows the last frame handed to the CODEC.
    if (fifo_empty) begin
      head = last_q;
    end else begin
      head = fifo_dout;
    end
  end

  // Pairing and status registers.
  always_ff @(posedge ck) begin
    if (!rst) begin
      held_l_q   <= 1'b0;
      held_r_q   <= 1'b0;
      hold_l_q   <= {DATA_W{1'b0}};
      hold_r_q   <= {DATA_W{1'b0}};
      overflow_q <= 1'b0;
      pair_err_q <= 1'b0;
      last_q     <= {FW{1'b0}};
    end else begin
      held_l_q   <= held_l_d;
      held_r_q   <= held_r_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      overflow_q <= overflow_d;
      pair_err_q <= pair_err_d;
      last_q     <= last_d;
    end
  end

`ifdef WRBUF_STATS_EN
  logic [DROP_W-1:0] drop_count_q, drop_count_d;

  assign drop_count = drop_count_q;

  // Discarded-frame counter next value.
  always_comb begin
    if (dropped) begin
      drop_count_d = sat_inc(drop_count_q);
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // Discarded-frame counter register.
  always_ff @(posedge ck) begin
    if (!rst) begin
      drop_count_q <= {DROP_W{1'b0}};
    end else begin
      drop_count_q <= drop_count_d;
    end
  end
`else
`endif

endmodule

// File: tb/tb_stereo_write_buffer.sv
// Self-checking bench: directed table, corner sequences, random vs queue model.
module tb_stereo_write_buffer;
  import wrbuf_pkg::*;

  localparam int DEPTH = 8;

  logic        ck;
  logic        rst;
  logic [15:0] in_left, in_right;
  logic        in_left_valid, in_right_valid;
  logic        write_ready;
  logic        write;
  logic [23:0] writedata_left, writedata_right;
  logic [3:0]  level;
  logic        overflow, pair_err;
`ifdef WRBUF_STATS_EN
  logic [15:0] drop_count;
`endif

  stereo_write_buffer #(.DATA_W(16), .DEPTH(DEPTH)) dut (
    .ck              (ck),
    .rst             (rst),
    .in_left         (in_left),
    .in_left_valid   (in_left_valid),
    .in_right        (in_right),
    .in_right_valid  (in_right_valid),
    .write_ready     (write_ready),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .level           (level),
    .overflow        (overflow),
`ifdef WRBUF_STATS_EN
    .pair_err        (pair_err),
    .drop_count      (drop_count)
`else
    .pair_err        (pair_err)
`endif
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;

  // Reference model: a queue of frames plus per-channel pending samples.
  frame_t      mq[$];
  frame_t      m_last;
  logic        m_held_l, m_held_r;
  logic [15:0] m_hold_l, m_hold_r;
  logic        m_ovf, m_perr;
  logic [15:0] m_drops;

  typedef struct {
    logic        lv;
    logic [15:0] l;
    logic        rv;
    logic [15:0] r;
    logic        wr;
    logic        e_write;
    logic [23:0] e_wdl;
    logic [23:0] e_wdr;
    logic [3:0]  e_level;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last   = '0;
    m_held_l = 1'b0;
    m_held_r = 1'b0;
    m_hold_l = 16'h0000;
    m_hold_r = 16'h0000;
    m_ovf    = 1'b0;
    m_perr   = 1'b0;
    m_drops  = 16'h0000;
  endtask

  task automatic model_step(input logic lv, input logic [15:0] l,
                            input logic rv, input logic [15:0] r, input logic wr);
    int     sz;
    logic   pop;
    frame_t f;
    sz  = mq.size();
    pop = (sz != 0) && wr;
    f.left  = lv ? l : m_hold_l;
    f.right = rv ? r : m_hold_r;
    if (pop) m_last = mq.pop_front();
    if ((m_held_l || lv) && (m_held_r || rv)) begin
      if (sz == DEPTH && !pop) begin
        m_ovf = 1'b1;
        if (m_drops != 16'hFFFF) m_drops = m_drops + 16'h0001;
      end else begin
        mq.push_back(f);
      end
      m_held_l = 1'b0;
      m_held_r = 1'b0;
    end else begin
      if (lv) begin
        if (m_held_l) m_perr = 1'b1;
        m_held_l = 1'b1;
        m_hold_l = l;
      end
      if (rv) begin
        if (m_held_r) m_perr = 1'b1;
        m_held_r = 1'b1;
        m_hold_r = r;
      end
    end
  endtask

  task automatic check_model();
    frame_t h;
    logic   e_write;
    h       = (mq.size() != 0) ? mq[0] : m_last;
    e_write = (mq.size() != 0) && write_ready;
    chk("write", 32'(write), 32'(e_write));
    chk("wdata_left", 32'(writedata_left), 32'({h.left, 8'h00}));
    chk("wdata_right", 32'(writedata_right), 32'({h.right, 8'h00}));
    chk("level", 32'(level), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("pair_err", 32'(pair_err), 32'(m_perr));
`ifdef WRBUF_STATS_EN
    chk("drop_count", 32'(drop_count), 32'(m_drops));
`endif
  endtask

  task automatic drive(input logic lv, input logic [15:0] l,
                       input logic rv, input logic [15:0] r, input logic wr);
    in_left_valid  = lv;
    in_left        = l;
    in_right_valid = rv;
    in_right       = r;
    write_ready    = wr;
  endtask

  task automatic advance();
    @(posedge ck);
    model_step(in_left_valid, in_left, in_right_valid, in_right, write_ready);
    cyc_n++;
    #1;
  endtask

  task automatic cyc(input logic lv, input logic [15:0] l,
                     input logic rv, input logic [15:0] r, input logic wr);
    drive(lv, l, rv, r, wr);
    #3;
    check_model();
    advance();
  endtask

  task automatic do_reset();
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    rst = 1'b0;
    @(posedge ck);
    model_reset();
    cyc_n = 0;
    #1;
    rst = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_write"}, 32'(write), 32'd0);
    chk({tag, "_wdl"}, 32'(writedata_left), 32'd0);
    chk({tag, "_wdr"}, 32'(writedata_right), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_pair_err"}, 32'(pair_err), 32'd0);
  endtask

  initial begin
    logic lv, rv, wr;

    tbl[0] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 24'h000000, 24'h000000, 4'd0};
    tbl[1] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 24'h000000, 24'h000000, 4'd0};
    tbl[2] = '{1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 24'h000000, 24'h000000, 4'd0};
    tbl[3] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 24'h000000, 24'h000000, 4'd0};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 24'h000000, 24'h000000, 4'd0};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 16'hABCD, 1'b1, 1'b0, 24'h000000, 24'h000000, 4'd0};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 24'h123400, 24'hABCD00, 4'd1};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 24'h123400, 24'hABCD00, 4'd0};

    rst = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    model_reset();
    repeat (2) @(posedge ck);
    #1;
    rst = 1'b1;
    #3;
    check_all_zero("reset_init");

    // Pairing order: left at cycle 2, right at cycle 5, write in cycle 6 only.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].lv, tbl[i].l, tbl[i].rv, tbl[i].r, tbl[i].wr);
      #3;
      chk("tbl_write", 32'(write), 32'(tbl[i].e_write));
      chk("tbl_wdl", 32'(writedata_left), 32'(tbl[i].e_wdl));
      chk("tbl_wdr", 32'(writedata_right), 32'(tbl[i].e_wdr));
      chk("tbl_level", 32'(level), 32'(tbl[i].e_level));
      check_model();
      advance();
    end

    // Simultaneous pairing, then a lost left sample.
    do_reset();
    cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 16'h0001, 1'b1, 16'h0002, 1'b1);
    chk("simul_wdl", 32'(writedata_left), 32'h000100);
    chk("simul_wdr", 32'(writedata_right), 32'h000200);
    cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 16'h0020, 1'b0, 16'h0000, 1'b1);
    chk("lost_pair_err", 32'(pair_err), 32'd1);
    cyc(1'b0, 16'h0000, 1'b1, 16'h0030, 1'b1);
    chk("lost_wdl", 32'(writedata_left), 32'h002000);
    chk("lost_wdr", 32'(writedata_right), 32'h003000);
    repeat (2) cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);

    // Fill past capacity with the CODEC stalled, then drain.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b1, 16'(16'h0200 + i), 1'b0);
    chk("fill_level", 32'(level), 32'd8);
    chk("fill_overflow", 32'(overflow), 32'd1);
    repeat (10) cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_last", 32'(writedata_left), 32'h010700);
`ifdef WRBUF_STATS_EN
    chk("drop_count_1", 32'(drop_count), 32'd1);
`endif

    // Full boundary: push and pop together while full.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h0300 + i), 1'b1, 16'(16'h0400 + i), 1'b0);
    cyc(1'b1, 16'h0099, 1'b1, 16'h0199, 1'b1);
    chk("full_level", 32'(level), 32'd8);
    chk("full_overflow", 32'(overflow), 32'd0);
    repeat (9) cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    chk("full_newlast", 32'(writedata_left), 32'h009900);

    // Reset with frames queued and a left sample pending.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h0500 + i), 1'b1, 16'(16'h0600 + i), 1'b0);
    cyc(1'b1, 16'h0777, 1'b0, 16'h0000, 1'b0);
    do_reset();
    #3;
    check_all_zero("mid_reset");
    cyc(1'b0, 16'h0000, 1'b1, 16'h0888, 1'b1);
    repeat (3) cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    chk("reset_nowrite_level", 32'(level), 32'd0);

    // Backpressure: write_ready toggles each cycle.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h0A00 + i), 1'b1, 16'(16'h0B00 + i), 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'(i % 2));

    // Random traffic; a held channel is not re-pulsed in a completing cycle.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      lv = ($urandom_range(0, 99) < 45);
      rv = ($urandom_range(0, 99) < 45);
      wr = ($urandom_range(0, 99) < (((i / 300) % 2 == 1) ? 80 : 25));
      if ((m_held_l || lv) && (m_held_r || rv)) begin
        if (m_held_l) lv = 1'b0;
        if (m_held_r) rv = 1'b0;
      end
      cyc(lv, 16'($urandom), rv, 16'($urandom), wr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
